// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file dump reader: register file
// geometry and the dump FSM state encoding.
package regfile_pkg;

  localparam int NUM_REGS  = 32;
  localparam int REG_IDX_W = 5;
  localparam int DATA_W    = 32;

  // State encoding constants, also used as the enum values below.
  localparam logic [1:0] ENC_IDLE = 2'd0;
  localparam logic [1:0] ENC_REQ  = 2'd1;
  localparam logic [1:0] ENC_SEND = 2'd2;
  localparam logic [1:0] ENC_DONE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = ENC_IDLE,
    ST_REQ  = ENC_REQ,
    ST_SEND = ENC_SEND,
    ST_DONE = ENC_DONE
  } state_t;

  // Register index following idx; wraps at NUM_REGS.
  function automatic logic [REG_IDX_W-1:0] next_idx(input logic [REG_IDX_W-1:0] idx);
    return idx + REG_IDX_W'(1);
  endfunction

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Register-file read port and dump stream bundle.
//
// Handshake semantics: the dump stream is strict valid/ready. A beat transfers
// on a rising edge where dump_valid and dump_ready are both high. Once
// dump_valid rises, dump_data/dump_index/dump_last stay stable and dump_valid
// stays high until that transfer. The read port is a request/grant pair:
// rf_read_reg is meaningful only on cycles where port_req and port_gnt are both
// high, and rf_read_data is the combinational read of rf_read_reg.
interface regfile_dump_reader_if;
  import regfile_pkg::*;

  logic                 port_req;
  logic                 port_gnt;
  logic [REG_IDX_W-1:0] rf_read_reg;
  logic [DATA_W-1:0]    rf_read_data;
  logic                 dump_valid;
  logic                 dump_ready;
  logic [DATA_W-1:0]    dump_data;
  logic [REG_IDX_W-1:0] dump_index;
  logic                 dump_last;

  // The dump reader side.
  modport master (
    output port_req, rf_read_reg, dump_valid, dump_data, dump_index, dump_last,
    input  port_gnt, rf_read_data, dump_ready
  );

  // The pipeline / register file / sink side.
  modport slave (
    input  port_req, rf_read_reg, dump_valid, dump_data, dump_index, dump_last,
    output port_gnt, rf_read_data, dump_ready
  );

endinterface

// File: rtl/regdump_beat_reg.sv
// Capture/hold stage for one dump beat. A capture loads data, index and last
// and raises valid; the beat is held unchanged until valid & ready.
module regdump_beat_reg
  import regfile_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 capture,
  input  logic [DATA_W-1:0]    data_in,
  input  logic [REG_IDX_W-1:0] index_in,
  input  logic                 last_in,
  input  logic                 ready,
  output logic                 valid,
  output logic [DATA_W-1:0]    data,
  output logic [REG_IDX_W-1:0] index,
  output logic                 last,
  output logic                 accept
);

  // A beat transfers when it is offered and the sink takes it.
  assign accept = valid & ready;

  // Beat register: load on capture, drop valid only after a transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      index <= '0;
      last  <= 1'b0;
    end else begin
      if (capture) begin
        valid <= 1'b1;
        data  <= data_in;
        index <= index_in;
        last  <= last_in;
      end else if (accept) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/regfile_dump_reader.sv
// Sequential register-file dump reader. Borrows one register file read port
// while the pipeline grants it and streams registers FIRST_REG..LAST_REG out
// as valid/ready beats. Optional running checksum of accepted beats is built
// when REGDUMP_CHECKSUM_EN is defined.
module regfile_dump_reader
  import regfile_pkg::*;
#(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   start,
  input  logic   abort,
  output logic   busy,
  output logic   done,
  output state_t state_dbg,
  regfile_dump_reader_if.master bus
`ifdef REGDUMP_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam logic [REG_IDX_W-1:0] FIRST_IDX = REG_IDX_W'(FIRST_REG);
  localparam logic [REG_IDX_W-1:0] LAST_IDX  = REG_IDX_W'(LAST_REG);

  state_t               state, state_nx;
  logic [REG_IDX_W-1:0] ptr, ptr_nx;
  logic [REG_IDX_W-1:0] rd_reg;
  logic                 abort_pend, abort_pend_nx;
  logic                 capture;
  logic                 start_ok;
  logic                 accept;

  // Control outputs are plain decodes of the state register so reset clears
  // them without waiting for a clock.
  assign busy         = (state != ST_IDLE);
  assign done         = (state == ST_DONE);
  assign bus.port_req = (state == ST_REQ);
  assign bus.rf_read_reg = rd_reg;
  assign state_dbg    = state;

  // Next-state, pointer and pending-abort logic.
  always_comb begin
    state_nx      = state;
    ptr_nx        = ptr;
    abort_pend_nx = abort_pend;
    capture       = 1'b0;
    start_ok      = 1'b0;
    case (state)
      ST_IDLE: begin
        abort_pend_nx = 1'b0;
        if (start) begin
          start_ok = 1'b1;
          ptr_nx   = FIRST_IDX;
          state_nx = ST_REQ;
        end
      end
      ST_REQ: begin
        // Abort beats a same-cycle grant: nothing is captured.
        if (abort) begin
          state_nx = ST_IDLE;
        end else if (bus.port_gnt) begin
          capture  = 1'b1;
          state_nx = ST_SEND;
        end
      end
      ST_SEND: begin
        // An abort here only takes effect once the beat on offer transfers.
        if (abort) begin
          abort_pend_nx = 1'b1;
        end
        if (accept) begin
          abort_pend_nx = 1'b0;
          if (abort_pend || abort) begin
            state_nx = ST_IDLE;
          end else if (bus.dump_last) begin
            state_nx = ST_DONE;
          end else begin
            ptr_nx   = next_idx(ptr);
            state_nx = ST_REQ;
          end
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // FSM state, pointer and pending-abort registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      ptr        <= FIRST_IDX;
      abort_pend <= 1'b0;
    end else begin
      state      <= state_nx;
      ptr        <= ptr_nx;
      abort_pend <= abort_pend_nx;
    end
  end

  // Read address follows the pointer on entry to REQ and holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_reg <= '0;
    end else if (state_nx == ST_REQ) begin
      rd_reg <= ptr_nx;
    end
  end

  regdump_beat_reg u_beat (
    .clk      (clk),
    .rst      (rst),
    .capture  (capture),
    .data_in  (bus.rf_read_data),
    .index_in (ptr),
    .last_in  (ptr == LAST_IDX),
    .ready    (bus.dump_ready),
    .valid    (bus.dump_valid),
    .data     (bus.dump_data),
    .index    (bus.dump_index),
    .last     (bus.dump_last),
    .accept   (accept)
  );

`ifdef REGDUMP_CHECKSUM_EN
  // Running sum of accepted beats; cleared by an accepted start, otherwise
  // held, so an aborted dump leaves its partial sum visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      checksum <= '0;
    end else if (start_ok) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= checksum + bus.dump_data;
    end
  end
`else
  // Accepted-start strobe only feeds the checksum; keep it referenced.
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader (FIRST_REG=0, LAST_REG=31).
// Build with REGDUMP_CHECKSUM_EN defined to also check the checksum.
module tb_regfile_dump_reader;
  import regfile_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  logic   start;
  logic   abort;
  logic   busy;
  logic   done;
  state_t state_dbg;
`ifdef REGDUMP_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  regfile_dump_reader_if bus ();

  regfile_dump_reader #(.FIRST_REG(0), .LAST_REG(31)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg),
    .bus       (bus)
`ifdef REGDUMP_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Register file model: combinational read, register 0 reads as zero.
  logic [31:0] rf_mem [32];
  assign bus.rf_read_data = (bus.rf_read_reg == 5'd0) ? 32'd0 : rf_mem[bus.rf_read_reg];

  int          n_pass = 0;
  int          n_chk  = 0;
  int          cyc_n  = 0;
  int          done_cnt = 0;
  int          done_at = 0;
  logic        busy_at_done = 1'b0;
  logic [31:0] cs_at_done = '0;
  logic [37:0] exp_q[$];

  task automatic chk(input string tag, input logic [37:0] obs, input logic [37:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Expected beats {last, index, data} for indices lo..hi of a 0..31 dump.
  task automatic push_beats(input int lo, input int hi);
    logic [31:0] d;
    for (int i = lo; i <= hi; i++) begin
      d = (i == 0) ? 32'd0 : (32'h1000 + 32'(i));
      exp_q.push_back({(i == 31), 5'(i), d});
    end
  endtask

  // One clock: score a beat about to transfer, advance, observe Done.
  task automatic cyc();
    logic [37:0] e;
    if (bus.dump_valid && bus.dump_ready) begin
      chk("beat_expected", 38'(exp_q.size() != 0), 38'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("beat", {bus.dump_last, bus.dump_index, bus.dump_data}, e);
      end
    end
    @(posedge clk);
    #1;
    cyc_n++;
    if (done) begin
      done_cnt++;
      done_at      = cyc_n;
      busy_at_done = busy;
`ifdef REGDUMP_CHECKSUM_EN
      cs_at_done   = checksum;
`endif
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    int d0;
    n  = 0;
    d0 = done_cnt;
    while (done_cnt == d0 && n < budget) begin
      cyc();
      n++;
    end
    chk(tag, 38'(done_cnt != d0), 38'd1);
  endtask

  task automatic wait_beat(input string tag, input logic [4:0] idx, input int budget);
    int n;
    n = 0;
    while (!(bus.dump_valid && bus.dump_index == idx) && n < budget) begin
      cyc();
      n++;
    end
    chk(tag, 38'(bus.dump_valid && bus.dump_index == idx), 38'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int d0;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    bus.port_gnt = 1'b0;
    bus.dump_ready = 1'b0;
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'h1000 + 32'(i);

    // Reset state
    #12;
    chk("rst_busy", 38'(busy), 38'd0);
    chk("rst_done", 38'(done), 38'd0);
    chk("rst_port_req", 38'(bus.port_req), 38'd0);
    chk("rst_valid", 38'(bus.dump_valid), 38'd0);
    chk("rst_data", 38'(bus.dump_data), 38'd0);
    chk("rst_index", 38'(bus.dump_index), 38'd0);
    chk("rst_last", 38'(bus.dump_last), 38'd0);
    chk("rst_rd_reg", 38'(bus.rf_read_reg), 38'd0);
    chk("rst_state", 38'(state_dbg), 38'(ST_IDLE));
`ifdef REGDUMP_CHECKSUM_EN
    chk("rst_checksum", 38'(checksum), 38'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    cyc();

    // Full dump with grant and ready held high
    push_beats(0, 31);
    bus.port_gnt = 1'b1;
    bus.dump_ready = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    s = cyc_n;
    chk("full_busy", 38'(busy), 38'd1);
    chk("full_port_req", 38'(bus.port_req), 38'd1);
    chk("full_rd_reg", 38'(bus.rf_read_reg), 38'd0);
    wait_done("full_done_seen", 100);
    chk("full_done_latency", 38'(done_at - s), 38'd64);
    chk("full_busy_with_done", 38'(busy_at_done), 38'd1);
`ifdef REGDUMP_CHECKSUM_EN
    chk("full_checksum", 38'(cs_at_done), 38'h1F1F0);
`endif
    chk("full_q_empty", 38'(exp_q.size()), 38'd0);
    cyc();
    chk("full_idle_busy", 38'(busy), 38'd0);
    chk("full_idle_state", 38'(state_dbg), 38'(ST_IDLE));

    // Backpressure on beat 7
    push_beats(0, 31);
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_beat("bp_reach_7", 5'd7, 40);
    bus.dump_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("bp_valid", 38'(bus.dump_valid), 38'd1);
      chk("bp_data", 38'(bus.dump_data), 38'h1007);
      chk("bp_index", 38'(bus.dump_index), 38'd7);
      chk("bp_no_req", 38'(bus.port_req), 38'd0);
    end
    bus.dump_ready = 1'b1;
    wait_done("bp_done_seen", 100);
    chk("bp_q_empty", 38'(exp_q.size()), 38'd0);
    cyc();

    // Grant starvation
    push_beats(0, 31);
    bus.port_gnt = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("gs_port_req", 38'(bus.port_req), 38'd1);
      chk("gs_no_valid", 38'(bus.dump_valid), 38'd0);
    end
    bus.port_gnt = 1'b1;
    cyc();
    chk("gs_valid", 38'(bus.dump_valid), 38'd1);
    chk("gs_index", 38'(bus.dump_index), 38'd0);
    chk("gs_data_r0", 38'(bus.dump_data), 38'd0);
    wait_done("gs_done_seen", 100);
    chk("gs_q_empty", 38'(exp_q.size()), 38'd0);
    cyc();

    // Abort in REQ at index 4
    push_beats(0, 3);
    start = 1'b1;
    cyc();
    start = 1'b0;
    s = 0;
    while (!(bus.port_req && bus.rf_read_reg == 5'd4) && s < 40) begin
      cyc();
      s++;
    end
    chk("ar_reach_4", 38'(bus.port_req && bus.rf_read_reg == 5'd4), 38'd1);
    d0 = done_cnt;
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("ar_state", 38'(state_dbg), 38'(ST_IDLE));
    chk("ar_busy", 38'(busy), 38'd0);
    chk("ar_valid", 38'(bus.dump_valid), 38'd0);
    repeat (3) cyc();
    chk("ar_no_done", 38'(done_cnt - d0), 38'd0);
    chk("ar_q_empty", 38'(exp_q.size()), 38'd0);

    // Abort in SEND at index 9
    push_beats(0, 9);
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_beat("as_reach_9", 5'd9, 40);
    d0 = done_cnt;
    bus.dump_ready = 1'b0;
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("as_valid_held", 38'(bus.dump_valid), 38'd1);
    chk("as_index_held", 38'(bus.dump_index), 38'd9);
    chk("as_busy", 38'(busy), 38'd1);
    bus.dump_ready = 1'b1;
    cyc();
    chk("as_state", 38'(state_dbg), 38'(ST_IDLE));
    chk("as_busy_low", 38'(busy), 38'd0);
    chk("as_valid_low", 38'(bus.dump_valid), 38'd0);
    repeat (3) cyc();
    chk("as_no_done", 38'(done_cnt - d0), 38'd0);
    chk("as_q_empty", 38'(exp_q.size()), 38'd0);

    // Reset mid-SEND, then a fresh dump from the first register
    bus.dump_ready = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_beat("rs_reach_0", 5'd0, 10);
    #2;
    rst = 1'b1;
    #1;
    chk("rs_valid", 38'(bus.dump_valid), 38'd0);
    chk("rs_busy", 38'(busy), 38'd0);
    chk("rs_port_req", 38'(bus.port_req), 38'd0);
    chk("rs_data", 38'(bus.dump_data), 38'd0);
    chk("rs_state", 38'(state_dbg), 38'(ST_IDLE));
    #2;
    rst = 1'b0;
    cyc();
    push_beats(0, 31);
    bus.dump_ready = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_done("rs_done_seen", 100);
`ifdef REGDUMP_CHECKSUM_EN
    chk("rs_checksum", 38'(cs_at_done), 38'h1F1F0);
`endif
    chk("rs_q_empty", 38'(exp_q.size()), 38'd0);
    cyc();

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
